// File: rtl/div_32_seq.sv
// Iterative restoring divider: S / T, signed or unsigned, fixed 33-cycle latency.
// Result packs {remainder, quotient} to match the multiplier's HI/LO layout.
module div_32_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   S,
    input  logic [WIDTH-1:0]   T,
    output logic               busy,
    output logic               done,
    output logic               dz,
    output logic [2*WIDTH-1:0] Y
);

    typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   dvd_q;
    logic               qneg_q, rneg_q, zero_q;
    logic               done_q, dz_q;
    logic [2*WIDTH-1:0] y_q;

    logic [WIDTH-1:0]   s_mag, t_mag;
    logic [WIDTH:0]     r_shift, r_sub;
    logic               r_ge;
    logic [WIDTH-1:0]   q_fix, r_low, r_fix;
    logic               last_iter;

    // 0x80000000 negates to itself, which is already the correct unsigned magnitude.
    assign s_mag     = (sgn && S[WIDTH-1]) ? -S : S;
    assign t_mag     = (sgn && T[WIDTH-1]) ? -T : T;
    assign r_shift   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign r_ge      = r_shift >= {1'b0, div_q};
    assign r_sub     = r_shift - {1'b0, div_q};
    assign r_low     = rem_q[WIDTH-1:0];
    assign q_fix     = qneg_q ? -quo_q : quo_q;
    assign r_fix     = rneg_q ? -r_low : r_low;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIter;
            StIter:  if (last_iter) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = done_q;
        dz   = dz_q;
        Y    = y_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            dvd_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            y_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        quo_q  <= s_mag;
                        div_q  <= t_mag;
                        dvd_q  <= S;
                        qneg_q <= sgn & (S[WIDTH-1] ^ T[WIDTH-1]);
                        rneg_q <= sgn & S[WIDTH-1];
                        zero_q <= (T == '0);
                        rem_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                StIter: begin
                    rem_q <= r_ge ? r_sub : r_shift;
                    quo_q <= {quo_q[WIDTH-2:0], r_ge};
                    cnt_q <= cnt_q + 1'b1;
                end
                StFix: begin
                    // Divide-by-zero result is forced, bypassing the sign fix-up.
                    y_q    <= zero_q ? {dvd_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
                    dz_q   <= zero_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq: scoreboard of {dz, Y} expectations
// pushed at start and popped when done is observed.
module tb_div_32_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] S = '0;
    logic [31:0] T = '0;
    logic        busy, done, dz;
    logic [63:0] Y;

    int tests_run = 0;
    int tests_failed = 0;
    logic [64:0] sb[$];

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [64:0] exp;
    } vec_t;

    div_32_seq dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .sgn  (sgn),
        .S    (S),
        .T    (T),
        .busy (busy),
        .done (done),
        .dz   (dz),
        .Y    (Y)
    );

    always #5 clk = ~clk;

    // Independent reference built on native SV division: returns {dz, rem, quo}.
    function automatic logic [64:0] model(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa, sb_, q, r;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
            sa  = a;
            sb_ = b;
            q   = sa / sb_;
            r   = sa % sb_;
            return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
    endfunction

    task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [64:0] exp);
        @(negedge clk);
        sgn   = s;
        S     = a;
        T     = b;
        start = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        S     = $urandom;
        T     = $urandom;
        sgn   = ~s;
    endtask

    // Returns negedges after the start edge at which done was seen; 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (done) lat = k;
        end
    endtask

    task automatic run_vectors(input string name, input vec_t v[]);
        int lat;
        logic [64:0] e;
        foreach (v[i]) begin
            do_start(v[i].s, v[i].a, v[i].b, v[i].exp);
            wait_done(lat);
            tests_run++;
            if (lat !== 33) begin
                tests_failed++;
                $display("FAIL %s[%0d] latency: got %0d expected 33", name, i, lat);
            end
            if (lat != 0 && sb.size() > 0) begin
                e = sb.pop_front();
                tests_run++;
                if ({dz, Y} !== e) begin
                    tests_failed++;
                    $display("FAIL %s[%0d] result: got dz=%b Y=%h expected dz=%b Y=%h",
                             name, i, dz, Y, e[64], e[63:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, dz, Y} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b Y=%h expected all 0",
                     busy, done, dz, Y);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_signed();
        vec_t v[] = '{
            '{1'b1, 32'd100,       32'd7,         {1'b0, 64'h0000_0002_0000_000E}},
            '{1'b1, 32'hFFFF_FF9C, 32'd7,         {1'b0, 64'hFFFF_FFFE_FFFF_FFF2}},
            '{1'b1, 32'd100,       32'hFFFF_FFF9, {1'b0, 64'h0000_0002_FFFF_FFF2}}};
        int lat;
        // Busy shape checked once explicitly on a fresh division.
        do_start(1'b1, 32'd50, 32'd5, {1'b0, 64'h0000_0000_0000_000A});
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        wait_done(lat);
        tests_run++;
        if (busy !== 1'b0 || lat !== 33) begin
            tests_failed++;
            $display("FAIL busy_at_done: got busy=%b lat=%0d expected busy=0 lat=33", busy, lat);
        end
        if (sb.size() > 0) void'(sb.pop_front());
        run_vectors("signed", v);
    endtask

    task automatic test_unsigned_vs_signed();
        vec_t v[] = '{
            '{1'b0, 32'hFFFF_FFFF, 32'd2, {1'b0, 64'h0000_0001_7FFF_FFFF}},
            '{1'b1, 32'hFFFF_FFFF, 32'd2, {1'b0, 64'hFFFF_FFFF_0000_0000}}};
        run_vectors("uns_vs_sgn", v);
    endtask

    task automatic test_corners();
        vec_t v[] = '{
            '{1'b1, 32'd5,         32'd0,         {1'b1, 64'h0000_0005_FFFF_FFFF}},
            '{1'b0, 32'hDEAD_BEEF, 32'd0,         {1'b1, 64'hDEAD_BEEF_FFFF_FFFF}},
            '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 64'h0000_0000_8000_0000}},
            '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 64'h8000_0000_0000_0000}}};
        run_vectors("corner", v);
    endtask

    task automatic test_random();
        vec_t v[] = new[10];
        foreach (v[i]) begin
            v[i].s = 1'($urandom);
            v[i].a = $urandom;
            v[i].b = (i % 3 == 0) ? $urandom_range(0, 9) : $urandom;
            if (i == 5) v[i].b = 32'hFFFF_FFFF;
            v[i].exp = model(v[i].s, v[i].a, v[i].b);
        end
        run_vectors("random", v);
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        logic [64:0] e;
        do_start(1'b1, 32'd100, 32'd7, {1'b0, 64'h0000_0002_0000_000E});
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (done) lat = k;
            if (k == 10) begin
                start = 1'b1;
                sgn   = 1'b0;
                S     = 32'd9;
                T     = 32'd4;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL ignore_start latency: got %0d expected 33", lat);
        end
        if (lat != 0 && sb.size() > 0) begin
            e = sb.pop_front();
            tests_run++;
            if ({dz, Y} !== e) begin
                tests_failed++;
                $display("FAIL ignore_start result: got %h expected %h", {dz, Y}, e);
            end
        end
        // A spurious second operation would leave the divider busy here.
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [64:0] e;
        logic [63:0] first_y = 64'h0000_0002_0000_000E;
        do_start(1'b1, 32'd100, 32'd7, {1'b0, first_y});
        wait_done(lat);
        // Issue the next request in the same cycle done is high.
        start = 1'b1;
        sgn   = 1'b0;
        S     = 32'd9;
        T     = 32'd4;
        sb.push_back({1'b0, 64'h0000_0001_0000_0002});
        if (sb.size() > 0) e = sb.pop_front();
        tests_run++;
        if (lat !== 33 || {dz, Y} !== e) begin
            tests_failed++;
            $display("FAIL b2b first: got lat=%0d Y=%h expected lat=33 Y=%h", lat, Y, e[63:0]);
        end
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (Y !== first_y || done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b hold: got Y=%h done=%b busy=%b expected Y=%h done=0 busy=1",
                     Y, done, busy, first_y);
        end
        wait_done(lat);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL b2b second latency: got %0d expected 33", lat);
        end
        if (lat != 0 && sb.size() > 0) begin
            e = sb.pop_front();
            tests_run++;
            if ({dz, Y} !== e) begin
                tests_failed++;
                $display("FAIL b2b second result: got %h expected %h", {dz, Y}, e);
            end
        end
    endtask

    task automatic test_reset_midop();
        int n_done = 0;
        vec_t v[] = '{'{1'b1, 32'd1000, 32'd3, {1'b0, 64'h0000_0001_0000_014D}}};
        do_start(1'b1, 32'd77, 32'd0, {1'b1, 64'h0000_004D_FFFF_FFFF});
        repeat (14) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, dz, Y} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_midop: got busy=%b done=%b dz=%b Y=%h expected all 0",
                     busy, done, dz, Y);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        tests_run++;
        if (n_done !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: got %0d done pulses expected 0", n_done);
        end
        run_vectors("after_reset", v);
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned_vs_signed();
        test_corners();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
